// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encoding, datapath width and
// PC alignment helpers used by instruction_fetch and instruction_decoder.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Word-align a PC by clearing the two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequences one word read per instruction, honours PC
// redirects from execute and hands each fetched word to the decoder via valid/ready.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rbusy,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            take_rsp;

  // A response is only kept when nothing (old or same-cycle redirect) has invalidated it.
  assign take_rsp = (state_q == WAIT) && !mem_rbusy && !kill_q && !redirect_valid;

  // Next-state, PC and output-holding register logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // The strobe leaves this cycle regardless; a redirect only marks it stale.
        kill_d  = kill_q | redirect_valid;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_rbusy) begin
          kill_d  = kill_q | redirect_valid;
          state_d = WAIT;
        end else if (kill_q || redirect_valid) begin
          kill_d  = 1'b0;
          state_d = REQ;
        end else begin
          instr_d    = mem_rdata;
          instr_pc_d = req_pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready || redirect_valid) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (take_rsp) begin
      pc_d = req_pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  // req_pc is loaded on entry to REQ so mem_addr is already valid with the strobe.
  always_comb begin
    req_pc_d = req_pc_q;
    if (state_d == REQ) begin
      req_pc_d = pc_d;
    end else begin
      req_pc_d = req_pc_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      req_pc_q   <= RESET_ADDR;
      kill_q     <= 1'b0;
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_addr    = req_pc_q;
  assign mem_rstrb   = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// phase, checked against a transfer-level PC model and a wait-state memory model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_ADDR = 32'h0000_0100;

  logic        clk;
  logic        resetn;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instruction_fetch #(.RESET_ADDR(RST_ADDR)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_addr       (mem_addr),
    .mem_rstrb      (mem_rstrb),
    .mem_rdata      (mem_rdata),
    .mem_rbusy      (mem_rbusy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = -1;
  int          rst_cnt  = 0;
  int          rst_age  = 0;
  bit          pend     = 1'b0;
  bit          stale    = 1'b0;
  int          cnt      = 0;
  int          wait_n   = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc    = RST_ADDR;
  logic [31:0] rd_match  = 32'h0;
  logic [31:0] rd_target = 32'h0;
  logic [31:0] stall_pc  = 32'h0;
  int          rd_cond   = 0;
  int          rd_cyc    = 0;
  int          stall_left  = 0;
  int          stall_start = 0;
  int          xfers     = 0;
  bit          rnd_mode  = 1'b0;
  int          sq_cyc[$];
  logic [31:0] sq_addr[$];
  int          xq_cyc[$];
  logic [31:0] xq_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // First strobe strictly after cycle c must be at addr (and at exp_c when >= 0).
  task automatic check_strobe(input string tag, input int c, input logic [31:0] addr, input int exp_c);
    int idx = -1;
    for (int i = 0; i < sq_cyc.size(); i++) begin
      if (idx < 0 && sq_cyc[i] > c) idx = i;
    end
    if (idx < 0) begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_addr"}, sq_addr[idx], addr);
      if (exp_c >= 0) check_eq({tag, "_cyc"}, sq_cyc[idx], exp_c);
    end
  endtask

  // First transfer strictly after cycle c must carry pc (and happen at exp_c when >= 0).
  task automatic check_xfer(input string tag, input int c, input logic [31:0] pc, input int exp_c);
    int idx = -1;
    for (int i = 0; i < xq_cyc.size(); i++) begin
      if (idx < 0 && xq_cyc[i] > c) idx = i;
    end
    if (idx < 0) begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_pc"}, xq_pc[idx], pc);
      if (exp_c >= 0) check_eq({tag, "_cyc"}, xq_cyc[idx], exp_c);
    end
  endtask

  task automatic clear_logs();
    sq_cyc.delete(); sq_addr.delete(); xq_cyc.delete(); xq_pc.delete();
  endtask

  task automatic tick();
    bit fire;
    @(posedge clk); #1;
    // drive phase
    if (rd_cond == 4 && pend && !stale && cnt != 0) begin
      rst_cnt = 2; rd_cond = 0; clear_logs();
    end
    if (rst_cnt > 0) begin
      resetn = 1'b0; rst_cnt--; cyc = -1; rst_age++;
    end else begin
      resetn = 1'b1; cyc++; rst_age = 0;
    end
    if (pend) begin
      mem_rbusy = (cnt != 0);
      mem_rdata = mem_rbusy ? $urandom : mem_word(pend_addr);
    end else begin
      mem_rbusy = 1'b0;
      mem_rdata = $urandom;
    end
    if (rnd_mode) begin
      instr_ready = ($urandom_range(0, 9) < 7);
    end else if (instr_valid && stall_left > 0) begin
      if (stall_left == 5) begin stall_start = cyc; stall_pc = exp_pc; end
      instr_ready = 1'b0;
      stall_left--;
    end else begin
      instr_ready = 1'b1;
    end
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (resetn) begin
      case (rd_cond)
        1: fire = pend && !stale && cnt != 0 && pend_addr == rd_match;
        2: fire = pend && !stale && cnt == 0 && pend_addr == rd_match;
        3: fire = instr_valid && instr_ready && instr_pc == rd_match;
        default: fire = 1'b0;
      endcase
      if (rnd_mode && $urandom_range(0, 31) == 0) begin
        fire = 1'b1; rd_target = $urandom;
      end
      if (fire) begin
        redirect_valid = 1'b1; redirect_pc = rd_target; rd_cond = 0; rd_cyc = cyc;
      end
    end
    // sample and model phase
    @(negedge clk);
    if (!resetn) begin
      if (rst_age >= 2) begin
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
      end
      exp_pc = RST_ADDR;
      if (pend) stale = 1'b1;
    end else begin
      if (cyc == 0) begin
        check_eq("c0_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("c0_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check_eq("c0_instr", instruction, 32'd0);
        check_eq("c0_ipc", instr_pc, 32'd0);
      end
      if (instr_valid) begin
        check_eq("instr_pc", instr_pc, exp_pc);
        check_eq("instr_data", instruction, mem_word(exp_pc));
      end
      if (instr_valid && instr_ready) begin
        xfers++; xq_cyc.push_back(cyc); xq_pc.push_back(instr_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    if (resetn && mem_rstrb) begin
      sq_cyc.push_back(cyc); sq_addr.push_back(mem_addr);
      pend = 1'b1; stale = 1'b0; pend_addr = mem_addr;
      cnt = rnd_mode ? $urandom_range(0, 3) : wait_n;
    end else if (pend) begin
      if (resetn && !stale) check_eq("addr_stable", mem_addr, pend_addr);
      if (cnt == 0) pend = 1'b0;
      else cnt--;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_cnt = 2; clear_logs();
  endtask

  int x0;

  initial begin
    resetn = 1'b0; mem_rdata = 32'h0; mem_rbusy = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;

    // reset and sequential fetch, zero-wait memory
    do_reset(); wait_n = 0; run(11);
    check_strobe("seq0", 0, 32'h100, 1);
    check_strobe("seq1", 1, 32'h104, 4);
    check_strobe("seq2", 4, 32'h108, 7);
    check_xfer("seq_first", -1, 32'h100, 3);

    // three wait states per fetch
    wait_n = 3; clear_logs(); run(16);
    check_eq("wait_nstrobes", {31'd0, sq_cyc.size() >= 2}, 32'd1);
    if (sq_cyc.size() >= 2) check_eq("wait_period", sq_cyc[1] - sq_cyc[0], 32'd6);

    // consumer stall of five cycles
    wait_n = 0; stall_left = 5; clear_logs(); run(14);
    check_eq("stall_done", stall_left, 32'd0);
    check_xfer("stall_x", stall_start, stall_pc, stall_start + 5);
    check_strobe("stall_s", stall_start, stall_pc + 32'd4, stall_start + 6);

    // redirect while fetch of 0x104 is busy
    do_reset(); wait_n = 3; rd_cond = 1; rd_match = 32'h104; rd_target = 32'h2003; run(30);
    check_eq("rdwait_fired", rd_cond, 32'd0);
    check_strobe("rdwait_s", rd_cyc, 32'h2000, -1);
    check_xfer("rdwait_x", rd_cyc, 32'h2000, -1);

    // redirect in the very cycle the response arrives
    wait_n = 1; rd_cond = 2; rd_match = exp_pc + 32'd8; rd_target = 32'h3000; run(20);
    check_eq("rdrsp_fired", rd_cond, 32'd0);
    check_strobe("rdrsp_s", rd_cyc, 32'h3000, rd_cyc + 1);
    check_xfer("rdrsp_x", rd_cyc, 32'h3000, -1);

    // redirect in HOLD with the consumer ready
    wait_n = 0; rd_cond = 3; rd_match = exp_pc + 32'd4; rd_target = 32'h4000; run(20);
    check_eq("rdhold_fired", rd_cond, 32'd0);
    check_xfer("rdhold_old", rd_cyc - 1, rd_match, rd_cyc);
    check_strobe("rdhold_s", rd_cyc, 32'h4000, rd_cyc + 1);
    check_xfer("rdhold_new", rd_cyc, 32'h4000, -1);

    // PC wrap at the top of the address space
    rd_cond = 3; rd_match = exp_pc + 32'd4; rd_target = 32'hFFFF_FFFE; run(20);
    check_eq("wrap_fired", rd_cond, 32'd0);
    check_strobe("wrap0", rd_cyc, 32'hFFFF_FFFC, rd_cyc + 1);
    check_strobe("wrap1", rd_cyc + 1, 32'h0000_0000, rd_cyc + 4);

    // reset asserted mid-WAIT; the late response must be ignored
    wait_n = 4; rd_cond = 4; run(22);
    check_eq("rstw_fired", rd_cond, 32'd0);
    check_strobe("rstw_s", -1, RST_ADDR, 1);
    check_xfer("rstw_x", -1, RST_ADDR, 7);

    // randomized traffic against the model
    do_reset(); rnd_mode = 1'b1; x0 = xfers; run(1500);
    check_eq("rnd_progress", {31'd0, (xfers - x0) >= 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the RISC-V core: holds the program counter, issues one word-aligned read per instruction to instruction memory, and presents the returned word with its PC to `instruction_decoder` over a valid/ready handshake. It accepts PC redirects from execute for branches and jumps, and discards any fetch in flight when a redirect occurs.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `mem_addr`  out  32  fetch address. Stable from the strobe cycle until the response is taken.
- `mem_rstrb`  out  1  one-cycle read strobe.
- `mem_rdata`  in  32  read data. Valid in the first cycle after the strobe in which `mem_rbusy`=0.
- `mem_rbusy`  in  1  memory not yet ready with data.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  32  new PC. Bits [1:0] are ignored and treated as 0.
- `instruction`  out  32  fetched word, presented to the decoder.
- `instr_pc`  out  32  address of `instruction`.
- `instr_valid`  out  1  `instruction` and `instr_pc` are valid.
- `instr_ready`  in  1  the consumer accepts the word. A transfer occurs when `instr_valid` and `instr_ready` are both 1.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_pc`: address currently issued; drives `mem_addr`.
  - `kill`: in-flight response is to be dropped.
  - `state`.
  - `instruction`, `instr_pc`: output holding registers.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - **IDLE** (entered only from reset): go to REQ.
  - **REQ**: `req_pc<=pc`; `mem_rstrb`=1; go to WAIT.
    - `mem_rstrb` is decoded as (state==REQ).
    - `req_pc` is loaded on entry to REQ, so `mem_addr` is already correct in the strobe cycle.
  - **WAIT**: while `mem_rbusy`=1, stay in WAIT. When `mem_rbusy`=0:
    - If `kill`=1: drop the data, clear `kill`, go to REQ.
    - Otherwise: `instruction<=mem_rdata`, `instr_pc<=req_pc`, `pc<=req_pc+4`, go to HOLD.
  - **HOLD**: `instr_valid`=1, decoded as (state==HOLD).
    - On a transfer, go to REQ.
    - Otherwise hold all outputs unchanged.
- Redirect (highest priority, any state other than during reset): `pc<=redirect_pc & ~32'h3`.
  - IDLE: go to REQ.
  - REQ: the strobe still goes out; set `kill`; go to WAIT.
  - WAIT: set `kill`.
    - If the response arrives in the same cycle, drop it, go to REQ, and leave `kill`=0.
    - The PC update from that response is suppressed.
  - HOLD: go to REQ; `instr_valid` is 0 from the next cycle.
    - If `instr_ready`=1 in the same cycle, that transfer still counts as completed.
  - Repeated redirects: the last one wins.
- Arithmetic: `pc+4` is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset values (while `resetn`=0):
  - `state`=IDLE, `pc`=`RESET_ADDR`, `req_pc`=`RESET_ADDR`, `kill`=0.
  - `instruction`=0, `instr_pc`=0, `instr_valid`=0, `mem_rstrb`=0.
- Reset is accepted in any state.
  - An outstanding memory response after reset is ignored, because WAIT is not re-entered until a new strobe is issued.
- Cycle 0 is the first cycle with `resetn`=1.
  - Cycle 0: IDLE.
  - Cycle 1: REQ, strobe at `RESET_ADDR`.
  - With a zero-wait memory, data is taken in cycle 2 and `instr_valid`=1 in cycle 3.
- Steady-state throughput with zero wait states and a consumer that is always ready: one instruction every 3 cycles.
  - Each memory wait cycle adds 1.
  - Each consumer stall cycle adds 1.
- Redirect to a new fetch: the redirect in cycle N produces the strobe at the new PC in cycle N+1 when in HOLD or IDLE.
  - In REQ or WAIT, the new strobe comes one cycle after the killed response is drained.
- Outputs `instruction` and `instr_pc` are registered. `instr_valid` and `mem_rstrb` are decoded from `state` with no combinational path from any input.

## Structure
- `riscv_pkg`, shared with `instruction_decoder`, holds:
  - the `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD);
  - `XLEN`=32;
  - `INSTR_NOP`=32'h0000_0013;
  - `PC_ALIGN_MASK`=32'hFFFF_FFFC.
- No sub-module: the FSM, PC adder and output register form one module.

## Test plan
- **Reset and sequential fetch.** `RESET_ADDR`=32'h100, zero-wait memory, `instr_ready`=1 → strobes at 0x100 (cycle 1), 0x104 (cycle 4), 0x108 (cycle 7). The outputs carry matching `instr_pc` and data.
- **Wait states.** `mem_rbusy` is high for 3 cycles after each strobe → `mem_addr` stays stable and the period is 6 cycles.
- **Consumer stall.** `instr_ready`=0 for 5 cycles in HOLD → `instruction` and `instr_pc` stay constant, no new strobe is issued, and the next strobe follows the transfer.
- **Redirect in WAIT.** Redirect to 32'h2003 while the fetch of 0x104 is busy → the 0x104 data is never presented; the next strobe is at 0x2000 and `instr_pc`=0x2000.
- **Redirect coinciding with the response, and redirect in HOLD with `instr_ready`=1.**
  - Coinciding with the response: the data is dropped and the next fetch is at the redirect target.
  - In HOLD with `instr_ready`=1: the transfer completes and the next `instr_pc` is the target.
- **Wrap and mid-operation reset.**
  - Fetch at 0xFFFF_FFFC → next strobe at 0x0.
  - Assert `resetn`=0 during WAIT → `instr_valid`=0, then the restart fetches `RESET_ADDR` and the late response is ignored.
